// File: rtl/sm3_pkg.sv
// Shared constants, state encoding and byte-lane helpers for the SM3 padding front end.
package sm3_pkg;

  localparam int unsigned BLOCK_W   = 512;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned HASH_W    = 256;
  localparam int unsigned NUM_WORDS = BLOCK_W / WORD_W;

  localparam logic [HASH_W-1:0] SM3_IV =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StPad,
    StLen,
    StHash
  } state_e;

  // Keep the first nbytes bytes of a big-endian word; 4 or more keeps all.
  function automatic logic [WORD_W-1:0] byte_mask(input logic [2:0] nbytes);
    unique case (nbytes)
      3'd0:    byte_mask = 32'h0000_0000;
      3'd1:    byte_mask = 32'hff00_0000;
      3'd2:    byte_mask = 32'hffff_0000;
      3'd3:    byte_mask = 32'hffff_ff00;
      default: byte_mask = 32'hffff_ffff;
    endcase
  endfunction

  // 0x80 in the first unused byte lane; nothing when the word is full.
  function automatic logic [WORD_W-1:0] pad80_at(input logic [2:0] nbytes);
    unique case (nbytes)
      3'd0:    pad80_at = 32'h8000_0000;
      3'd1:    pad80_at = 32'h0080_0000;
      3'd2:    pad80_at = 32'h0000_8000;
      3'd3:    pad80_at = 32'h0000_0080;
      default: pad80_at = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/sm3_pad_ctrl_if.sv
// Message stream, compression-core handshake and digest bundle for sm3_pad_ctrl.
interface sm3_pad_ctrl_if;
  import sm3_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [WORD_W-1:0]   in_data;
  logic [2:0]          in_bytes;
  logic                in_last;

  logic                cf_start;
  logic [HASH_W-1:0]   V1;
  logic [BLOCK_W-1:0]  msg_block;
  logic [HASH_W-1:0]   V2;
  logic                cf_end;

  logic [HASH_W-1:0]   digest;
  logic                digest_valid;

  // Pad controller side.
  modport master (
    input  in_valid, in_data, in_bytes, in_last, V2, cf_end,
    output in_ready, cf_start, V1, msg_block, digest, digest_valid
  );

  // Message source plus compression core side.
  modport slave (
    output in_valid, in_data, in_bytes, in_last, V2, cf_end,
    input  in_ready, cf_start, V1, msg_block, digest, digest_valid
  );

endinterface

// File: rtl/sm3_blk_buf.sv
// 16x32 message block register: indexed byte-masked word write with optional 0x80 insert,
// plus a dedicated port that loads the 64-bit length into words 14-15.
module sm3_blk_buf
  import sm3_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [3:0]          idx_i,
  input  logic [WORD_W-1:0]   data_i,
  input  logic [2:0]          nbytes_i,
  input  logic                ins80_i,
  input  logic                len_we_i,
  input  logic [63:0]         len_i,
  output logic [BLOCK_W-1:0]  block_o
);

  logic [WORD_W-1:0] mem_q [NUM_WORDS];
  logic [WORD_W-1:0] wdata;

  assign wdata = (data_i & byte_mask(nbytes_i)) | (ins80_i ? pad80_at(nbytes_i) : '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      if (we_i) mem_q[idx_i] <= wdata;
      if (len_we_i) begin
        mem_q[NUM_WORDS-2] <= len_i[63:32];
        mem_q[NUM_WORDS-1] <= len_i[31:0];
      end
    end
  end

  always_comb begin
    block_o = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      block_o[BLOCK_W-1-WORD_W*i -: WORD_W] = mem_q[i];
    end
  end

endmodule

// File: rtl/sm3_pad_ctrl.sv
// SM3 front end: packs words into blocks, pads, drives the CF core and chains V2 into V1.
// Define SM3_BLKCNT_EN to add the blk_cnt output counting completed compressions.
module sm3_pad_ctrl
  import sm3_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  sm3_pad_ctrl_if.master  bus
`ifdef SM3_BLKCNT_EN
  ,
  output logic [15:0]     blk_cnt
`endif
);

  state_e             state_q, state_d;
  logic [4:0]         widx_q, widx_d, widx_cur;
  logic [LEN_W-1:0]   bitlen_q, bitlen_d, bitlen_cur;
  logic               pend80_q, pend80_d;
  logic               extra_q, extra_d;
  logic               final_q, final_d;
  logic               cf_start_q, cf_start_d;
  logic               in_ready_q, in_ready_d;
  logic [HASH_W-1:0]  v1_q, v1_d;
  logic [HASH_W-1:0]  digest_q, digest_d;
  logic               digest_valid_q, digest_valid_d;

  logic               accept;
  logic               buf_we, buf_ins80, len_we;
  logic [3:0]         buf_idx;
  logic [WORD_W-1:0]  buf_data;
  logic [2:0]         buf_nbytes;
  logic [BLOCK_W-1:0] msg_block;

  assign accept     = bus.in_valid & in_ready_q;
  // A word taken in IDLE starts a fresh message.
  assign widx_cur   = (state_q == StIdle) ? '0 : widx_q;
  assign bitlen_cur = (state_q == StIdle) ? '0 : bitlen_q;

  always_comb begin
    state_d        = state_q;
    widx_d         = widx_q;
    bitlen_d       = bitlen_q;
    pend80_d       = pend80_q;
    extra_d        = extra_q;
    final_d        = final_q;
    v1_d           = v1_q;
    digest_d       = digest_q;
    digest_valid_d = digest_valid_q;
    buf_we         = 1'b0;
    buf_idx        = widx_cur[3:0];
    buf_data       = bus.in_data;
    buf_nbytes     = bus.in_bytes;
    buf_ins80      = 1'b0;
    len_we         = 1'b0;

    unique case (state_q)
      StIdle, StFill: begin
        if (state_q == StIdle) begin
          v1_d     = SM3_IV;
          widx_d   = '0;
          bitlen_d = '0;
          pend80_d = 1'b0;
          extra_d  = 1'b0;
          final_d  = 1'b0;
          state_d  = StFill;
        end
        if (accept) begin
          digest_valid_d = 1'b0;
          buf_we         = 1'b1;
          buf_ins80      = bus.in_last;
          bitlen_d       = bitlen_cur + LEN_W'({bus.in_bytes, 3'b000});
          widx_d         = widx_cur + 5'd1;
          if (bus.in_last) begin
            state_d  = StPad;
            pend80_d = bus.in_bytes[2];
          end else if (widx_cur == 5'd15) begin
            state_d = StHash;
          end
        end
      end
      StPad: begin
        if (widx_q == 5'd16) begin
          // Marker or length did not fit: this block goes out and an all-pad block follows.
          state_d = StHash;
          extra_d = 1'b1;
        end else if (widx_q == 5'd14 && !pend80_q) begin
          state_d = StLen;
        end else begin
          buf_we     = 1'b1;
          buf_idx    = widx_q[3:0];
          buf_data   = pend80_q ? 32'h8000_0000 : 32'h0000_0000;
          buf_nbytes = 3'd4;
          pend80_d   = 1'b0;
          widx_d     = widx_q + 5'd1;
        end
      end
      StLen: begin
        len_we  = 1'b1;
        final_d = 1'b1;
        state_d = StHash;
      end
      StHash: begin
        if (bus.cf_end) begin
          v1_d   = bus.V2;
          widx_d = '0;
          if (final_q) begin
            digest_d       = bus.V2;
            digest_valid_d = 1'b1;
            final_d        = 1'b0;
            state_d        = StIdle;
          end else if (extra_q) begin
            extra_d = 1'b0;
            state_d = StPad;
          end else begin
            state_d = StFill;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    cf_start_d = (state_d == StHash);
    in_ready_d = (state_d == StIdle) || (state_d == StFill);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      widx_q         <= '0;
      bitlen_q       <= '0;
      pend80_q       <= 1'b0;
      extra_q        <= 1'b0;
      final_q        <= 1'b0;
      cf_start_q     <= 1'b0;
      in_ready_q     <= 1'b0;
      v1_q           <= SM3_IV;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      widx_q         <= widx_d;
      bitlen_q       <= bitlen_d;
      pend80_q       <= pend80_d;
      extra_q        <= extra_d;
      final_q        <= final_d;
      cf_start_q     <= cf_start_d;
      in_ready_q     <= in_ready_d;
      v1_q           <= v1_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
    end
  end

  sm3_blk_buf u_blk_buf (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_i     (buf_we),
    .idx_i    (buf_idx),
    .data_i   (buf_data),
    .nbytes_i (buf_nbytes),
    .ins80_i  (buf_ins80),
    .len_we_i (len_we),
    .len_i    (64'(bitlen_q)),
    .block_o  (msg_block)
  );

  assign bus.in_ready     = in_ready_q;
  assign bus.cf_start     = cf_start_q;
  assign bus.V1           = v1_q;
  assign bus.msg_block    = msg_block;
  assign bus.digest       = digest_q;
  assign bus.digest_valid = digest_valid_q;

`ifdef SM3_BLKCNT_EN
  logic [15:0] blk_cnt_q, blk_cnt_d;

  // Held through digest_valid; restarts when the next message begins.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if ((state_q == StIdle && !digest_valid_q) || (accept && digest_valid_q)) begin
      blk_cnt_d = '0;
    end else if (state_q == StHash && bus.cf_end) begin
      blk_cnt_d = blk_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) blk_cnt_q <= '0;
    else     blk_cnt_q <= blk_cnt_d;
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sm3_pad_ctrl.sv
// Scoreboard bench for sm3_pad_ctrl with a behavioural SM3 compression core.
module tb_sm3_pad_ctrl;
  import sm3_pkg::*;

  localparam int CF_LAT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sm3_pad_ctrl_if bus ();
`ifdef SM3_BLKCNT_EN
  logic [15:0] blk_cnt;
`endif

  sm3_pad_ctrl #(.LEN_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SM3_BLKCNT_EN
    ,
    .blk_cnt (blk_cnt)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;
  int hold_knob = 0;

  logic [511:0] exp_blk_q [$];
  logic [255:0] exp_v1_q  [$];
  logic [255:0] exp_dig_q [$];

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    int s;
    s = n % 32;
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rol(x, 9) ^ rol(x, 17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rol(x, 15) ^ rol(x, 23);
  endfunction

  function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] blk);
    logic [31:0] w [68];
    logic [31:0] wp [64];
    logic [31:0] a, b, c, d, e, f, g, h, ss1, ss2, tt1, tt2, ff, gg, tj;
    for (int j = 0; j < 16; j++) w[j] = blk[511-32*j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1(w[j-16] ^ w[j-9] ^ rol(w[j-3], 15)) ^ rol(w[j-13], 7) ^ w[j-6];
    for (int j = 0; j < 64; j++) wp[j] = w[j] ^ w[j+4];
    {a, b, c, d, e, f, g, h} = v;
    for (int j = 0; j < 64; j++) begin
      tj  = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rol(rol(a, 12) + e + rol(tj, j), 7);
      ss2 = ss1 ^ rol(a, 12);
      ff  = (j < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
      gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
      tt1 = ff + d + ss2 + wp[j];
      tt2 = gg + h + ss1 + w[j];
      d = c;  c = rol(b, 9);  b = a;  a = tt1;
      h = g;  g = rol(f, 19); f = e;  e = p0(tt2);
    end
    return {a, b, c, d, e, f, g, h} ^ v;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Byte-level padding model; queues each block with the V1 it must be hashed under.
  task automatic push_msg(input logic [31:0] word, input int n, input logic [2:0] lb,
                          input logic [255:0] known, input bit use_known, input bit want_dig);
    logic [7:0]   mb [$];
    logic [63:0]  blen;
    logic [511:0] blk;
    logic [255:0] v;
    int           len;
    for (int i = 0; i < n; i++)
      for (int bi = 0; bi < 4; bi++)
        if (i < n - 1 || bi < int'(lb)) mb.push_back(word[31-8*bi -: 8]);
    len = mb.size();
    mb.push_back(8'h80);
    while (mb.size() % 64 != 56) mb.push_back(8'h00);
    blen = 64'(len) * 64'd8;
    for (int bi = 0; bi < 8; bi++) mb.push_back(blen[63-8*bi -: 8]);
    v = SM3_IV;
    for (int base = 0; base < mb.size(); base += 64) begin
      for (int k = 0; k < 64; k++) blk[511-8*k -: 8] = mb[base+k];
      exp_blk_q.push_back(blk);
      exp_v1_q.push_back(v);
      v = sm3_cf(v, blk);
    end
    if (want_dig) exp_dig_q.push_back(use_known ? known : v);
  endtask

  task automatic send_rep(input logic [31:0] word, input int n, input logic [2:0] lb);
    int waitc;
    for (int i = 0; i < n; i++) begin
      waitc = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = word;
      bus.in_bytes = (i == n - 1) ? lb : 3'd4;
      bus.in_last  = (i == n - 1);
      while (!bus.in_ready && waitc < 3000) begin
        @(negedge clk);
        waitc++;
      end
      if (!bus.in_ready) begin
        n_vec++;
        n_bad++;
        $display("FAIL in_ready_timeout: got 0 want 1 after %0d cycles", waitc);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (exp_dig_q.size() != 0 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check("drain_digests", 512'(exp_dig_q.size()), 512'd0);
  endtask

  // Compression core: result after CF_LAT cycles, cf_end held until cf_start drops
  // (plus hold_knob extra cycles), restart whenever cf_start is low.
  int cnt = 0;
  int hold = 0;
  always @(posedge clk) begin
    if (rst || !bus.cf_start) begin
      cnt <= 0;
      if (bus.cf_end && hold > 0) hold <= hold - 1;
      else                        bus.cf_end <= 1'b0;
    end else if (!bus.cf_end) begin
      if (cnt == CF_LAT) begin
        bus.V2     <= sm3_cf(bus.V1, bus.msg_block);
        bus.cf_end <= 1'b1;
        hold       <= hold_knob;
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  initial begin : monitor
    logic         prev_cf, prev_dv;
    logic [255:0] s_v1;
    logic [511:0] s_blk;
    prev_cf = 1'b0;
    prev_dv = 1'b0;
    s_v1    = '0;
    s_blk   = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.cf_start && !prev_cf) begin
          s_v1  = bus.V1;
          s_blk = bus.msg_block;
          if (exp_blk_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_block: got %h want none", bus.msg_block);
          end else begin
            check("msg_block", bus.msg_block, exp_blk_q.pop_front());
            check("V1_in", 512'(bus.V1), 512'(exp_v1_q.pop_front()));
          end
        end
        if (!bus.cf_start && prev_cf)
          check("V1_after_cf", 512'(bus.V1), 512'(sm3_cf(s_v1, s_blk)));
        if (bus.digest_valid && !prev_dv) begin
          if (exp_dig_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_digest: got %h want none", bus.digest);
          end else begin
            check("digest", 512'(bus.digest), 512'(exp_dig_q.pop_front()));
          end
        end
      end
      prev_cf = bus.cf_start;
      prev_dv = bus.digest_valid;
    end
  end

  initial begin : stim
    int c;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_bytes = '0;
    bus.in_last  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 512'(bus.in_ready), 512'd0);
    check("rst_cf_start", 512'(bus.cf_start), 512'd0);
    check("rst_V1", 512'(bus.V1), 512'(SM3_IV));
    check("rst_msg_block", bus.msg_block, 512'd0);
    check("rst_digest", 512'(bus.digest), 512'd0);
    check("rst_digest_valid", 512'(bus.digest_valid), 512'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    push_msg(32'h61626300, 1, 3'd3,
             256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0, 1, 1);
    send_rep(32'h61626300, 1, 3'd3);
    // Low bytes are junk here; the controller must mask them.
    push_msg(32'hdeadbeef, 1, 3'd0,
             256'h1ab21d83_55cfa17f_8e611948_31e81a8f_22bec8c7_28fefb74_7ed035eb_5082aa2b, 1, 1);
    send_rep(32'hdeadbeef, 1, 3'd0);
    push_msg(32'h61626364, 16, 3'd4,
             256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732, 1, 1);
    send_rep(32'h61626364, 16, 3'd4);
    push_msg(32'h61626364, 14, 3'd4, '0, 0, 1);
    send_rep(32'h61626364, 14, 3'd4);
    drain();

    // Reset while the core is busy.
    push_msg(32'h61626300, 1, 3'd3, '0, 0, 0);
    send_rep(32'h61626300, 1, 3'd3);
    c = 0;
    while (!bus.cf_start && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("cf_start_before_rst", 512'(bus.cf_start), 512'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cf_start", 512'(bus.cf_start), 512'd0);
    check("midrst_digest_valid", 512'(bus.digest_valid), 512'd0);
    check("midrst_V1", 512'(bus.V1), 512'(SM3_IV));
    @(posedge clk);
    #1 rst = 1'b0;

    push_msg(32'h61626300, 1, 3'd3,
             256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0, 1, 1);
    send_rep(32'h61626300, 1, 3'd3);

    // cf_end lingers after cf_start drops.
    hold_knob = 3;
    push_msg(32'h61626364, 16, 3'd4,
             256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732, 1, 1);
    send_rep(32'h61626364, 16, 3'd4);
    drain();
    repeat (6) @(negedge clk);
`ifdef SM3_BLKCNT_EN
    check("blk_cnt", 512'(blk_cnt), 512'd2);
`endif
    check("blk_queue_empty", 512'(exp_blk_q.size()), 512'd0);
    check("cf_start_idle", 512'(bus.cf_start), 512'd0);
    check("digest_valid_held", 512'(bus.digest_valid), 512'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
